pmp_fault_handler: RTL and testbench

PMP_FAULT_HANDLER -- requirements
Module: pmp_fault_handler

---
 rtl/pmp_fault_handler_if.sv | 31 +++
 rtl/pmp_fault_handler.sv | 123 ++++++++++++
 tb/tb_pmp_fault_handler.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmp_fault_handler_if.sv
// Access/trap bundle between the core-side PMP checker and the fault handler.
// The handler connects through the slave modport; the core side uses master.
interface pmp_fault_handler_if;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned CAUSE_W = 2;
    localparam int unsigned CNT_W   = 8;

    logic                 req_valid;
    logic [ADDR_W-1:0]    req_addr;
    logic                 req_read;
    logic                 req_write;
    logic                 access_granted;
    logic                 trap_ack;
    logic                 trap_req;
    logic [ADDR_W-1:0]    fault_addr;
    logic [CAUSE_W-1:0]   fault_cause;
    logic [CNT_W-1:0]     fault_count;
    logic                 fault_dropped;
    logic                 stall;
    logic                 locked;

    modport master (
        output req_valid, req_addr, req_read, req_write, access_granted, trap_ack,
        input  trap_req, fault_addr, fault_cause, fault_count, fault_dropped, stall, locked
    );

    modport slave (
        input  req_valid, req_addr, req_read, req_write, access_granted, trap_ack,
        output trap_req, fault_addr, fault_cause, fault_count, fault_dropped, stall, locked
    );
endinterface

// File: rtl/pmp_fault_handler.sv
// PMP access-fault handler: captures the first fault, raises a trap toward the
// core, and locks the core down if the trap is not acknowledged in time.
module pmp_fault_handler #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    pmp_fault_handler_if.slave bus
);
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned CAUSE_W = 2;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TMO_W   = 8;

    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] COUNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRAP   = 2'd1,
        ST_CLEAR  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TMO_W-1:0]     r_tmo;
    logic [TMO_W-1:0]     w_tmo_nxt;
    logic                 w_fault;
    logic                 w_capture;

    logic [ADDR_W-1:0]    r_fault_addr;
    logic [CAUSE_W-1:0]   r_fault_cause;
    logic [CNT_W-1:0]     r_fault_count;
    logic                 r_fault_dropped;
    logic                 r_trap_req;
    logic                 r_stall;
    logic                 r_locked;

    // An access with neither read nor write can never fault.
    always_comb begin
        w_fault = bus.req_valid & (bus.req_read | bus.req_write) & ~bus.access_granted;
    end

    // Next-state and timeout counter logic; an ack beats a simultaneous timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_tmo_nxt   = r_tmo;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fault) begin
                    w_state_nxt = ST_TRAP;
                    w_tmo_nxt   = '0;
                    w_capture   = 1'b1;
                end
            end
            ST_TRAP: begin
                if (bus.trap_ack) begin
                    w_state_nxt = ST_CLEAR;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nxt = ST_LOCKED;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            ST_CLEAR:  w_state_nxt = ST_IDLE;
            ST_LOCKED: w_state_nxt = ST_LOCKED;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    // Status flags are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trap_req <= 1'b0;
            r_stall    <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_trap_req <= (w_state_nxt == ST_TRAP);
            r_stall    <= (w_state_nxt != ST_IDLE);
            r_locked   <= (w_state_nxt == ST_LOCKED);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault_addr    <= '0;
            r_fault_cause   <= '0;
            r_fault_count   <= '0;
            r_fault_dropped <= 1'b0;
        end else begin
            if (w_capture) begin
                r_fault_addr  <= bus.req_addr;
                r_fault_cause <= {bus.req_write, bus.req_read};
            end
            if (w_fault && (r_fault_count != COUNT_MAX)) begin
                r_fault_count <= r_fault_count + CNT_W'(1);
            end
            if (w_fault && (r_state != ST_IDLE)) begin
                r_fault_dropped <= 1'b1;
            end
        end
    end

    assign bus.trap_req      = r_trap_req;
    assign bus.fault_addr    = r_fault_addr;
    assign bus.fault_cause   = r_fault_cause;
    assign bus.fault_count   = r_fault_count;
    assign bus.fault_dropped = r_fault_dropped;
    assign bus.stall         = r_stall;
    assign bus.locked        = r_locked;
endmodule

// File: tb/tb_pmp_fault_handler.sv
// Directed bench for pmp_fault_handler with ACK_TIMEOUT=16; expected values
// are hand-computed per scenario.
module tb_pmp_fault_handler;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    pmp_fault_handler_if bus_if ();

    pmp_fault_handler #(.ACK_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus_if.req_valid      = 1'b0;
        bus_if.req_addr       = 8'h00;
        bus_if.req_read       = 1'b0;
        bus_if.req_write      = 1'b0;
        bus_if.access_granted = 1'b1;
        bus_if.trap_ack       = 1'b0;
    endtask

    task automatic drive_access(input logic [7:0] addr, input logic rd, input logic wr,
                                input logic granted);
        bus_if.req_valid      = 1'b1;
        bus_if.req_addr       = addr;
        bus_if.req_read       = rd;
        bus_if.req_write      = wr;
        bus_if.access_granted = granted;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_in();
        rst = 1'b1;
        #2;
        total++;
        if ({bus_if.trap_req, bus_if.stall, bus_if.locked, bus_if.fault_dropped,
             bus_if.fault_cause, bus_if.fault_addr, bus_if.fault_count} !== 22'h0) begin
            bad++;
            $display("FAIL reset_outputs got trap=%b stall=%b lock=%b drop=%b cause=%b addr=%h cnt=%0d exp all zero",
                     bus_if.trap_req, bus_if.stall, bus_if.locked, bus_if.fault_dropped,
                     bus_if.fault_cause, bus_if.fault_addr, bus_if.fault_count);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_fault();
        do_reset();
        drive_access(8'h45, 1'b0, 1'b1, 1'b0);
        tick();
        idle_in();
        total++;
        if ({bus_if.trap_req, bus_if.stall, bus_if.locked} !== 3'b110) begin
            bad++;
            $display("FAIL single_flags got trap/stall/lock=%b exp=110",
                     {bus_if.trap_req, bus_if.stall, bus_if.locked});
        end
        total++;
        if ({bus_if.fault_addr, bus_if.fault_cause, bus_if.fault_count} !== {8'h45, 2'b10, 8'd1}) begin
            bad++;
            $display("FAIL single_capture got addr=%h cause=%b cnt=%0d exp addr=45 cause=10 cnt=1",
                     bus_if.fault_addr, bus_if.fault_cause, bus_if.fault_count);
        end
        tick();
        tick();
        bus_if.trap_ack = 1'b1;
        tick();
        bus_if.trap_ack = 1'b0;
        total++;
        if ({bus_if.trap_req, bus_if.stall, bus_if.locked} !== 3'b010) begin
            bad++;
            $display("FAIL single_clear got trap/stall/lock=%b exp=010",
                     {bus_if.trap_req, bus_if.stall, bus_if.locked});
        end
        tick();
        total++;
        if ({bus_if.trap_req, bus_if.stall, bus_if.locked, bus_if.fault_dropped} !== 4'b0000) begin
            bad++;
            $display("FAIL single_idle got trap/stall/lock/drop=%b exp=0000",
                     {bus_if.trap_req, bus_if.stall, bus_if.locked, bus_if.fault_dropped});
        end
        bus_if.trap_ack = 1'b1;
        tick();
        bus_if.trap_ack = 1'b0;
        total++;
        if ({bus_if.trap_req, bus_if.stall, bus_if.fault_addr} !== {2'b00, 8'h45}) begin
            bad++;
            $display("FAIL idle_ack_ignored got trap=%b stall=%b addr=%h exp trap=0 stall=0 addr=45",
                     bus_if.trap_req, bus_if.stall, bus_if.fault_addr);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        drive_access(8'h90, 1'b1, 1'b0, 1'b0);
        tick();
        idle_in();
        n = 0;
        for (int i = 0; i < 40 && bus_if.trap_req === 1'b1; i++) begin
            n++;
            tick();
        end
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL timeout_trap_len got=%0d exp=16", n);
        end
        total++;
        if ({bus_if.trap_req, bus_if.stall, bus_if.locked, bus_if.fault_cause, bus_if.fault_addr}
            !== {3'b011, 2'b01, 8'h90}) begin
            bad++;
            $display("FAIL timeout_locked got trap/stall/lock=%b cause=%b addr=%h exp 011 01 90",
                     {bus_if.trap_req, bus_if.stall, bus_if.locked}, bus_if.fault_cause, bus_if.fault_addr);
        end
        bus_if.trap_ack = 1'b1;
        tick();
        bus_if.trap_ack = 1'b0;
        drive_access(8'h11, 1'b1, 1'b1, 1'b0);
        tick();
        idle_in();
        tick();
        tick();
        total++;
        if ({bus_if.trap_req, bus_if.stall, bus_if.locked, bus_if.fault_dropped} !== 4'b0111) begin
            bad++;
            $display("FAIL locked_sticky got trap/stall/lock/drop=%b exp=0111",
                     {bus_if.trap_req, bus_if.stall, bus_if.locked, bus_if.fault_dropped});
        end
        total++;
        if ({bus_if.fault_addr, bus_if.fault_cause, bus_if.fault_count} !== {8'h90, 2'b01, 8'd2}) begin
            bad++;
            $display("FAIL locked_fault got addr=%h cause=%b cnt=%0d exp addr=90 cause=01 cnt=2",
                     bus_if.fault_addr, bus_if.fault_cause, bus_if.fault_count);
        end
    endtask

    task automatic test_ack_timeout_tie();
        do_reset();
        drive_access(8'h33, 1'b1, 1'b0, 1'b0);
        tick();
        idle_in();
        for (int i = 0; i < 15; i++) tick();
        total++;
        if (bus_if.trap_req !== 1'b1) begin
            bad++;
            $display("FAIL tie_trap16 got=%b exp=1", bus_if.trap_req);
        end
        bus_if.trap_ack = 1'b1;
        tick();
        bus_if.trap_ack = 1'b0;
        total++;
        if ({bus_if.trap_req, bus_if.stall, bus_if.locked} !== 3'b010) begin
            bad++;
            $display("FAIL tie_clear got trap/stall/lock=%b exp=010",
                     {bus_if.trap_req, bus_if.stall, bus_if.locked});
        end
        tick();
        total++;
        if ({bus_if.trap_req, bus_if.stall, bus_if.locked} !== 3'b000) begin
            bad++;
            $display("FAIL tie_idle got trap/stall/lock=%b exp=000",
                     {bus_if.trap_req, bus_if.stall, bus_if.locked});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_access(8'h80, 1'b0, 1'b1, 1'b0);
        tick();
        drive_access(8'hA0, 1'b1, 1'b0, 1'b0);
        tick();
        idle_in();
        total++;
        if ({bus_if.fault_addr, bus_if.fault_cause, bus_if.fault_count, bus_if.fault_dropped}
            !== {8'h80, 2'b10, 8'd2, 1'b1}) begin
            bad++;
            $display("FAIL b2b got addr=%h cause=%b cnt=%0d drop=%b exp addr=80 cause=10 cnt=2 drop=1",
                     bus_if.fault_addr, bus_if.fault_cause, bus_if.fault_count, bus_if.fault_dropped);
        end
        total++;
        if (bus_if.trap_req !== 1'b1) begin
            bad++;
            $display("FAIL b2b_trap got=%b exp=1", bus_if.trap_req);
        end
    endtask

    task automatic test_non_faults();
        do_reset();
        drive_access(8'h22, 1'b0, 1'b0, 1'b0);
        tick();
        drive_access(8'h23, 1'b1, 1'b1, 1'b1);
        tick();
        bus_if.req_valid      = 1'b0;
        bus_if.access_granted = 1'b0;
        tick();
        idle_in();
        total++;
        if ({bus_if.trap_req, bus_if.stall, bus_if.fault_count} !== {2'b00, 8'd0}) begin
            bad++;
            $display("FAIL non_fault got trap=%b stall=%b cnt=%0d exp trap=0 stall=0 cnt=0",
                     bus_if.trap_req, bus_if.stall, bus_if.fault_count);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        drive_access(8'h5A, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) tick();
        total++;
        if (bus_if.fault_count !== 8'd200) begin
            bad++;
            $display("FAIL sat_mid got=%0d exp=200", bus_if.fault_count);
        end
        for (int i = 0; i < 100; i++) tick();
        total++;
        if (bus_if.fault_count !== 8'd255) begin
            bad++;
            $display("FAIL sat_full got=%0d exp=255", bus_if.fault_count);
        end
        drive_access(8'h5B, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        idle_in();
        total++;
        if ({bus_if.fault_count, bus_if.fault_addr, bus_if.locked} !== {8'd255, 8'h5A, 1'b1}) begin
            bad++;
            $display("FAIL sat_hold got cnt=%0d addr=%h lock=%b exp cnt=255 addr=5a lock=1",
                     bus_if.fault_count, bus_if.fault_addr, bus_if.locked);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_access(8'h77, 1'b0, 1'b1, 1'b0);
        tick();
        idle_in();
        tick();
        rst = 1'b1;
        #1;
        total++;
        if ({bus_if.trap_req, bus_if.stall, bus_if.locked, bus_if.fault_dropped,
             bus_if.fault_cause, bus_if.fault_addr, bus_if.fault_count} !== 22'h0) begin
            bad++;
            $display("FAIL reset_in_trap got trap=%b stall=%b lock=%b drop=%b cause=%b addr=%h cnt=%0d exp all zero",
                     bus_if.trap_req, bus_if.stall, bus_if.locked, bus_if.fault_dropped,
                     bus_if.fault_cause, bus_if.fault_addr, bus_if.fault_count);
        end
        tick();
        rst = 1'b0;
        tick();
        drive_access(8'h78, 1'b1, 1'b0, 1'b0);
        tick();
        idle_in();
        for (int i = 0; i < 18; i++) tick();
        total++;
        if (bus_if.locked !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_locked got=%b exp=1", bus_if.locked);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({bus_if.trap_req, bus_if.stall, bus_if.locked, bus_if.fault_dropped,
             bus_if.fault_cause, bus_if.fault_addr, bus_if.fault_count} !== 22'h0) begin
            bad++;
            $display("FAIL reset_in_locked got trap=%b stall=%b lock=%b drop=%b cause=%b addr=%h cnt=%0d exp all zero",
                     bus_if.trap_req, bus_if.stall, bus_if.locked, bus_if.fault_dropped,
                     bus_if.fault_cause, bus_if.fault_addr, bus_if.fault_count);
        end
        tick();
        rst = 1'b0;
        tick();
        drive_access(8'h12, 1'b1, 1'b1, 1'b0);
        tick();
        idle_in();
        total++;
        if ({bus_if.trap_req, bus_if.stall, bus_if.locked, bus_if.fault_addr, bus_if.fault_cause,
             bus_if.fault_count} !== {3'b110, 8'h12, 2'b11, 8'd1}) begin
            bad++;
            $display("FAIL first_after_reset got trap/stall/lock=%b addr=%h cause=%b cnt=%0d exp 110 12 11 1",
                     {bus_if.trap_req, bus_if.stall, bus_if.locked}, bus_if.fault_addr,
                     bus_if.fault_cause, bus_if.fault_count);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_in();
        test_reset();
        test_single_fault();
        test_timeout();
        test_ack_timeout_tie();
        test_back_to_back();
        test_non_faults();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
